// File: rtl/seg_scanner.sv
// Time-multiplexed 7-segment scan driver: per-frame snapshot of the digit codes,
// blanking guard at each slot start, per-digit blink, registered pin outputs.
module seg_scanner #(
    parameter int DIGIT_CNT      = 6,
    parameter int DIV            = 50000,
    parameter int BLANK          = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIGIT_CNT*7-1:0] seg_in,
    input  logic [DIGIT_CNT-1:0]   blink_mask,
    output logic [6:0]             seg_out,
    output logic [DIGIT_CNT-1:0]   dig_sel,
    output logic                   frame_start
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGIT_CNT);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0]           SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGIT_CNT-1:0] SEL_POL = (SEL_ACTIVE_LOW != 0) ? {DIGIT_CNT{1'b1}}
                                                                      : {DIGIT_CNT{1'b0}};

    typedef enum logic {
        SLOT_BLANK,
        SLOT_DRIVE
    } slot_e;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   phase_q, phase_d;
    logic [DIGIT_CNT*7-1:0] snap_seg_q;
    logic [DIGIT_CNT-1:0]   snap_mask_q;

    logic                   cnt_last, idx_last, fcnt_last, frame_wrap, snap_load;
    logic [6:0]             digit_seg;
    logic                   digit_mask;
    slot_e                  slot;
    logic [6:0]             seg_d;
    logic [DIGIT_CNT-1:0]   sel_d;

    always_comb begin
        cnt_last   = (cnt_q == CW'(DIV - 1));
        idx_last   = (idx_q == IW'(DIGIT_CNT - 1));
        fcnt_last  = (fcnt_q == FW'(BLINK_FRAMES - 1));
        frame_wrap = cnt_last && idx_last;
        snap_load  = (cnt_q == '0) && (idx_q == '0);

        cnt_d   = cnt_last ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        if (cnt_last) begin
            idx_d = idx_last ? '0 : idx_q + IW'(1);
        end
        fcnt_d  = fcnt_q;
        if (frame_wrap) begin
            fcnt_d = fcnt_last ? '0 : fcnt_q + FW'(1);
        end
        phase_d = phase_q ^ (frame_wrap && fcnt_last);

        // Select the current digit's snapshot code and blink bit
        digit_seg  = '0;
        digit_mask = 1'b0;
        for (int i = 0; i < DIGIT_CNT; i++) begin
            if (idx_q == IW'(i)) begin
                digit_seg  = snap_seg_q[i*7 +: 7];
                digit_mask = snap_mask_q[i];
            end
        end

        // A blinked-off digit is treated exactly like the blanking guard
        if ((cnt_q >= CW'(BLANK)) && !(phase_q && digit_mask)) begin
            slot = SLOT_DRIVE;
        end else begin
            slot = SLOT_BLANK;
        end

        seg_d = '0;
        sel_d = '0;
        if (slot == SLOT_DRIVE) begin
            seg_d = digit_seg;
            for (int i = 0; i < DIGIT_CNT; i++) begin
                sel_d[i] = (idx_q == IW'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
            snap_seg_q  <= '0;
            snap_mask_q <= '0;
            seg_out     <= SEG_POL;
            dig_sel     <= SEL_POL;
            frame_start <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
            if (snap_load) begin
                snap_seg_q  <= seg_in;
                snap_mask_q <= blink_mask;
            end
            seg_out     <= seg_d ^ SEG_POL;
            dig_sel     <= sel_d ^ SEL_POL;
            frame_start <= snap_load;
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: a frame/slot arithmetic model predicts every output
// cycle under directed and randomized seg_in / blink_mask / en / rst stimulus.
module tb_seg_scanner;

    localparam int DC  = 3;
    localparam int DV  = 4;
    localparam int BL  = 1;
    localparam int BF  = 2;
    localparam int LEN = DC * DV;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DC*7-1:0]   seg_in;
    logic [DC-1:0]     blink_mask;
    logic [6:0]        seg_out;
    logic [DC-1:0]     dig_sel;
    logic              frame_start;

    int checks = 0;
    int errors = 0;

    // Model state: enabled cycles since run start and the current frame snapshot
    int              pos = 0;
    logic [DC*7-1:0] mSnapSeg  = '0;
    logic [DC-1:0]   mSnapMask = '0;
    logic [6:0]      expSeg;
    logic [DC-1:0]   expSel;
    logic            expFs;

    seg_scanner #(
        .DIGIT_CNT(DC), .DIV(DV), .BLANK(BL), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .blink_mask(blink_mask),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Predict the outputs after the next edge from the inputs it will sample, then advance
    task automatic tick();
        int fr, p, idx, cnt, ph;
        logic [6:0] d;
        if (rst || !en) begin
            expSeg = 7'h7F;
            expSel = '1;
            expFs  = 1'b0;
            pos    = 0;
        end else begin
            fr  = pos / LEN;
            p   = pos % LEN;
            idx = p / DV;
            cnt = p % DV;
            ph  = (fr / BF) % 2;
            if (p == 0) begin
                mSnapSeg  = seg_in;
                mSnapMask = blink_mask;
            end
            expFs  = (p == 0);
            expSeg = 7'h7F;
            expSel = '1;
            if (cnt >= BL && !(ph == 1 && mSnapMask[idx])) begin
                d      = mSnapSeg[idx*7 +: 7];
                expSeg = ~d;
                expSel = ~(3'b001 << idx);
            end
            pos++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [DC*7-1:0] s, input logic [DC-1:0] m);
        rst = 1'b1;
        en  = 1'b1;
        seg_in = s;
        blink_mask = m;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            seg_in     = {$urandom, $urandom};
            blink_mask = 3'($urandom);
            en         = 1'($urandom);
            tick();
            checks++;
            if ({seg_out, dig_sel, frame_start} !== {7'h7F, 3'b111, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset cyc%0d: got seg=%h sel=%b fs=%b, want seg=7f sel=111 fs=0",
                         i, seg_out, dig_sel, frame_start);
            end
        end
    endtask

    task automatic test_basic_scan();
        start_run({7'h06, 7'h5B, 7'h3F}, 3'b000);
        while (pos < 14) begin
            tick();
            checks++;
            if ({seg_out, dig_sel, frame_start} !== {expSeg, expSel, expFs}) begin
                errors++;
                $display("[TB] FAIL basic_scan cyc%0d: got seg=%h sel=%b fs=%b, want seg=%h sel=%b fs=%b",
                         pos, seg_out, dig_sel, frame_start, expSeg, expSel, expFs);
            end
            if (pos == 3 || pos == 11 || pos == 13) begin
                checks++;
                if ((pos == 3  && {seg_out, dig_sel} !== {7'h40, 3'b110}) ||
                    (pos == 11 && {seg_out, dig_sel} !== {7'h79, 3'b011}) ||
                    (pos == 13 && frame_start !== 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL basic_fixed cyc%0d: got seg=%h sel=%b fs=%b",
                             pos, seg_out, dig_sel, frame_start);
                end
            end
        end
    endtask

    task automatic test_snapshot_isolation();
        start_run({7'h06, 7'h5B, 7'h3F}, 3'b000);
        while (pos < 21) begin
            tick();
            if (pos == 6) seg_in[13:7] = 7'h4F;
            checks++;
            if ({seg_out, dig_sel, frame_start} !== {expSeg, expSel, expFs}) begin
                errors++;
                $display("[TB] FAIL snapshot cyc%0d: got seg=%h sel=%b fs=%b, want seg=%h sel=%b fs=%b",
                         pos, seg_out, dig_sel, frame_start, expSeg, expSel, expFs);
            end
            if (pos == 7 || pos == 19) begin
                checks++;
                if (seg_out !== ((pos == 7) ? 7'h24 : 7'h30)) begin
                    errors++;
                    $display("[TB] FAIL snapshot_fixed cyc%0d: got seg=%h", pos, seg_out);
                end
            end
        end
    endtask

    task automatic test_blink();
        start_run({7'h06, 7'h5B, 7'h3F}, 3'b010);
        while (pos < 6 * LEN + 1) begin
            tick();
            checks++;
            if ({seg_out, dig_sel, frame_start} !== {expSeg, expSel, expFs}) begin
                errors++;
                $display("[TB] FAIL blink cyc%0d: got seg=%h sel=%b fs=%b, want seg=%h sel=%b fs=%b",
                         pos, seg_out, dig_sel, frame_start, expSeg, expSel, expFs);
            end
            if ((pos - 1) / LEN == 2 || (pos - 1) / LEN == 3) begin
                checks++;
                if (dig_sel[1] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL blink_off cyc%0d: got sel=%b, want digit 1 inactive", pos, dig_sel);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        start_run({7'h06, 7'h5B, 7'h3F}, 3'b000);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 7) en = 1'b0;
            if (i == 9) en = 1'b1;
            checks++;
            if ({seg_out, dig_sel, frame_start} !== {expSeg, expSel, expFs}) begin
                errors++;
                $display("[TB] FAIL enable_drop step%0d: got seg=%h sel=%b fs=%b, want seg=%h sel=%b fs=%b",
                         i, seg_out, dig_sel, frame_start, expSeg, expSel, expFs);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        start_run({$urandom, $urandom}, 3'($urandom));
        for (int i = 0; i < 60; i++) begin
            tick();
            seg_in     = {$urandom, $urandom};
            blink_mask = 3'($urandom);
            rst        = (i == 30);
            checks++;
            if ({seg_out, dig_sel, frame_start} !== {expSeg, expSel, expFs}) begin
                errors++;
                $display("[TB] FAIL reset_mid step%0d: got seg=%h sel=%b fs=%b, want seg=%h sel=%b fs=%b",
                         i, seg_out, dig_sel, frame_start, expSeg, expSel, expFs);
            end
        end
    endtask

    task automatic test_random();
        start_run({$urandom, $urandom}, 3'($urandom));
        for (int i = 0; i < 600; i++) begin
            tick();
            seg_in = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) blink_mask = 3'($urandom);
            en  = ($urandom_range(0, 79) != 0);
            rst = ($urandom_range(0, 149) == 0);
            checks++;
            if ({seg_out, dig_sel, frame_start} !== {expSeg, expSel, expFs}) begin
                errors++;
                $display("[TB] FAIL random step%0d: got seg=%h sel=%b fs=%b, want seg=%h sel=%b fs=%b",
                         i, seg_out, dig_sel, frame_start, expSeg, expSel, expFs);
            end
            checks++;
            if ($countones(~dig_sel) > 1) begin
                errors++;
                $display("[TB] FAIL one_hot step%0d: got sel=%b, want at most one active", i, dig_sel);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        seg_in     = '0;
        blink_mask = '0;
        test_reset();
        test_basic_scan();
        test_snapshot_isolation();
        test_blink();
        test_enable_drop();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
